adc_pack: RTL and testbench

Framing stage between the ADC byte stream and FIFO D. On each start flag from the central controller it writes one frame into FIFO D: a 5-byte header, the ADC payload and an optional checksum. It then reports the frame length that the FIFO-D-to-MAC stage uses as its UDP length. Payload bytes pass through an internal 8-entry buffer, so ADC bytes that arrive while the header is being emitted are not lost.

---
 rtl/adc_pack_if.sv | 26 ++
 rtl/adc_pack.sv | 187 ++++++++++++++++++
 tb/tb_adc_pack.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pack_if.sv
// Signal bundle between adc_pack and its environment (controller, ADC byte source, FIFO D).
// The slave modport is the framer's view; master is the view of whatever drives it.
interface adc_pack_if;
    logic        fs;
    logic        fd;
    logic        adc_rxen;
    logic [7:0]  adc_rxd;
    logic [9:0]  adc_rx_len;
    logic [7:0]  dev_kind;
    logic [7:0]  dev_smpr;
    logic        fifod_txen;
    logic [7:0]  fifod_txd;
    logic        fifod_full;
    logic [11:0] data_len;
    logic        err;

    modport slave (
        input  fs, adc_rxen, adc_rxd, adc_rx_len, dev_kind, dev_smpr, fifod_full,
        output fd, fifod_txen, fifod_txd, data_len, err
    );

    modport master (
        output fs, adc_rxen, adc_rxd, adc_rx_len, dev_kind, dev_smpr, fifod_full,
        input  fd, fifod_txen, fifod_txd, data_len, err
    );
endinterface

// File: rtl/adc_pack.sv
// Frames ADC payload bytes into FIFO D behind a 5-byte header (55 AA kind smpr seq).
// Define ADC_PACK_CHK_EN to append an XOR checksum byte after the payload.
module adc_pack #(
    parameter int DEPTH = 8
) (
    input logic       clk,
    input logic       rst,
    adc_pack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        DATA,
`ifdef ADC_PACK_CHK_EN
        TAIL,
`endif
        DONE
    } state_t;

`ifdef ADC_PACK_CHK_EN
    localparam state_t      AFTER_DATA = TAIL;
    localparam logic [11:0] HDR_PLUS   = 12'd6;
`else
    localparam state_t      AFTER_DATA = DONE;
    localparam logic [11:0] HDR_PLUS   = 12'd5;
`endif

    state_t          state, state_next;
    logic [9:0]      plen, acc_cnt, wr_cnt;
    logic [2:0]      hdr_idx;
    logic [7:0]      seq;
    logic [7:0]      hdr_byte;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic            push, push_ok, drop, pop;
    logic            emit;
    logic [7:0]      emit_byte;
    logic            vld_p1;
    logic [7:0]      txd_p1;
    logic            done;
    logic [11:0]     len;
    logic            ovf;
`ifdef ADC_PACK_CHK_EN
    logic [7:0]      chk;
`endif

    assign bus.fifod_txen = vld_p1;
    assign bus.fifod_txd  = txd_p1;
    assign bus.fd         = done;
    assign bus.data_len   = len;
    assign bus.err        = ovf;

    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_byte = 8'h55;
            3'd1:    hdr_byte = 8'hAA;
            3'd2:    hdr_byte = bus.dev_kind;
            3'd3:    hdr_byte = bus.dev_smpr;
            default: hdr_byte = seq;
        endcase
    end

    // Bytes past plen are ignored; a byte meeting a full buffer is lost but still counted.
    always_comb begin
        push    = ((state == HEAD) || (state == DATA)) && bus.adc_rxen && (acc_cnt < plen);
        drop    = push && (count == FULL_CNT);
        push_ok = push && !drop;
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_byte  = 8'h00;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fs) state_next = HEAD;
            end
            HEAD: begin
                if (!bus.fs) begin
                    state_next = IDLE;
                end else if (!bus.fifod_full) begin
                    emit      = 1'b1;
                    emit_byte = hdr_byte;
                    if (hdr_idx == 3'd4) begin
                        if (plen == 10'd0) state_next = AFTER_DATA;
                        else               state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (!bus.fs) begin
                    state_next = IDLE;
                end else if ((count != '0) && !bus.fifod_full) begin
                    pop       = 1'b1;
                    emit      = 1'b1;
                    emit_byte = mem[rd_ptr];
                end else if ((wr_cnt == plen) && (acc_cnt == plen)) begin
                    state_next = AFTER_DATA;
                end
            end
`ifdef ADC_PACK_CHK_EN
            TAIL: begin
                if (!bus.fs) begin
                    state_next = IDLE;
                end else if (!bus.fifod_full) begin
                    emit       = 1'b1;
                    emit_byte  = chk;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (!bus.fs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.adc_rxd;
    end

    // Stage p1: registered FIFO D write port and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            plen    <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            hdr_idx <= '0;
            seq     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            vld_p1  <= 1'b0;
            txd_p1  <= 8'h00;
            done    <= 1'b0;
            len     <= '0;
            ovf     <= 1'b0;
`ifdef ADC_PACK_CHK_EN
            chk     <= 8'h00;
`endif
        end else begin
            state  <= state_next;
            vld_p1 <= emit;
            if (emit) txd_p1 <= emit_byte;
            done   <= (state == DONE) && bus.fs;
            if ((state_next == DONE) && (state != DONE)) seq <= seq + 8'd1;

            if (state == IDLE) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                acc_cnt <= '0;
                wr_cnt  <= '0;
                hdr_idx <= '0;
                if (bus.fs) begin
                    plen <= bus.adc_rx_len;
                    len  <= {2'b00, bus.adc_rx_len} + HDR_PLUS;
                    ovf  <= 1'b0;
`ifdef ADC_PACK_CHK_EN
                    chk  <= 8'h00;
`endif
                end
            end else begin
                if (push)    acc_cnt <= acc_cnt + 10'd1;
                if (push_ok) wr_ptr  <= wr_ptr + PTR_ONE;
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    wr_cnt <= wr_cnt + 10'd1;
                end
                count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
                if (drop) ovf <= 1'b1;
                if ((state == HEAD) && emit) hdr_idx <= hdr_idx + 3'd1;
`ifdef ADC_PACK_CHK_EN
                if (emit) chk <= chk ^ emit_byte;
`endif
            end
        end
    end
endmodule

// File: tb/tb_adc_pack.sv
// Scoreboard bench for adc_pack: expected FIFO D bytes are queued as frames are started
// and matched against every write; frame-level flags are checked per scenario.
module tb_adc_pack;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_pack_if bus();

    adc_pack #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ADC_PACK_CHK_EN
    localparam int TAIL_N = 1;
`else
    localparam int TAIL_N = 0;
`endif

    int         total   = 0;
    int         bad     = 0;
    int         wr_seen = 0;
    logic       full_at_edge = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] tb_seq = 8'h00;

    always @(posedge clk) full_at_edge <= bus.fifod_full;

    always @(negedge clk) begin
        if (bus.fifod_txen === 1'b1) begin
            wr_seen++;
            total++;
            if (full_at_edge !== 1'b0) begin
                bad++;
                $display("FAIL write_while_full: txen=1 while full was %b at the edge", full_at_edge);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %h, expected no write", bus.fifod_txd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.fifod_txd !== mon_exp) begin
                    bad++;
                    $display("FAIL frame_byte: got %h, expected %h", bus.fifod_txd, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [7:0] kind, input logic [7:0] smpr,
                              input int npay, input bit with_tail);
        logic [7:0] hdr [5];
        logic [7:0] x;
        hdr = '{8'h55, 8'hAA, kind, smpr, tb_seq};
        x = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(hdr[i]);
            x ^= hdr[i];
        end
        for (int i = 1; i <= npay; i++) begin
            exp_q.push_back(8'(i));
            x ^= 8'(i);
        end
        if (with_tail && (TAIL_N == 1)) exp_q.push_back(x);
    endtask

    task automatic drive_frame(input logic [7:0] kind, input logic [7:0] smpr, input int plen,
                               input int nbytes, input int f0s, input int f0n,
                               input int f1s, input int f1n, input int ncyc);
        bus.dev_kind   = kind;
        bus.dev_smpr   = smpr;
        bus.adc_rx_len = 10'(plen);
        bus.fs         = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            bus.fifod_full = ((c >= f0s) && (c < f0s + f0n)) || ((c >= f1s) && (c < f1s + f1n));
            bus.adc_rxen   = (c < nbytes);
            bus.adc_rxd    = 8'(c + 1);
            @(posedge clk); #1;
        end
        bus.adc_rxen   = 1'b0;
        bus.fifod_full = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.fd === 1'b1) break;
        end
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        bus.fs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fs = 1'b0; bus.adc_rxen = 1'b0; bus.adc_rxd = 8'h00; bus.adc_rx_len = '0;
        bus.dev_kind = 8'h00; bus.dev_smpr = 8'h00; bus.fifod_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.fd !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b, expected 0", bus.fd); end
        total++; if (bus.fifod_txen !== 1'b0) begin bad++; $display("FAIL reset_txen: got %b, expected 0", bus.fifod_txen); end
        total++; if (bus.fifod_txd !== 8'h00) begin bad++; $display("FAIL reset_txd: got %h, expected 00", bus.fifod_txd); end
        total++; if (bus.data_len !== 12'h000) begin bad++; $display("FAIL reset_len: got %h, expected 000", bus.data_len); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, expected 0", bus.err); end
        @(posedge clk); #1;
        rst = 1'b0;
        tb_seq = 8'h00;
    endtask

    task automatic test_basic();
        logic [11:0] exp_len;
        exp_len = 12'(5 + TAIL_N + 4);
        push_frame(8'hFF, 8'hFA, 4, 1'b1);
        drive_frame(8'hFF, 8'hFA, 4, 4, 0, 0, 0, 0, 4);
        wait_fd(100);
        total++; if (bus.fd !== 1'b1) begin bad++; $display("FAIL basic_fd: got %b, expected 1", bus.fd); end
        total++; if (bus.data_len !== exp_len) begin bad++; $display("FAIL basic_len: got %h, expected %h", bus.data_len, exp_len); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b, expected 0", bus.err); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_missing: got %0d bytes unsent, expected 0", exp_q.size()); end
        end_frame();
        total++; if (bus.fd !== 1'b0) begin bad++; $display("FAIL basic_fd_fall: got %b, expected 0", bus.fd); end
        tb_seq++;
    endtask

    task automatic test_back_pressure();
        push_frame(8'hFF, 8'hFA, 4, 1'b1);
        drive_frame(8'hFF, 8'hFA, 4, 4, 1, 3, 8, 3, 12);
        wait_fd(100);
        total++; if (bus.fd !== 1'b1) begin bad++; $display("FAIL bp_fd: got %b, expected 1", bus.fd); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL bp_err: got %b, expected 0", bus.err); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_missing: got %0d bytes unsent, expected 0", exp_q.size()); end
        end_frame();
        tb_seq++;
    endtask

    task automatic test_overflow();
        logic [11:0] exp_len;
        exp_len = 12'(5 + TAIL_N + 12);
        push_frame(8'h11, 8'h22, 8, 1'b0);
        drive_frame(8'h11, 8'h22, 12, 12, 0, 20, 0, 0, 20);
        repeat (40) @(negedge clk);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b, expected 1", bus.err); end
        total++; if (bus.fd !== 1'b0) begin bad++; $display("FAIL ovf_fd: got %b, expected 0", bus.fd); end
        total++; if (bus.data_len !== exp_len) begin bad++; $display("FAIL ovf_len: got %h, expected %h", bus.data_len, exp_len); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_missing: got %0d bytes unsent, expected 0", exp_q.size()); end
        end_frame();
        @(negedge clk);
        total++; if (bus.fd !== 1'b0) begin bad++; $display("FAIL ovf_fd_after: got %b, expected 0", bus.fd); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky: got %b, expected 1", bus.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        int  base;
        bit  hit;
        base = wr_seen;
        hit  = 1'b0;
        push_frame(8'h33, 8'h44, 4, 1'b1);
        bus.dev_kind = 8'h33; bus.dev_smpr = 8'h44; bus.adc_rx_len = 10'd4; bus.fs = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; (c < 40) && !hit; c++) begin
            bus.adc_rxen = (c < 4);
            bus.adc_rxd  = 8'(c + 1);
            @(negedge clk); #1;
            if (wr_seen - base >= 7) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL mid_reach: got %0d writes, expected 7", wr_seen - base); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err_cleared: got %b, expected 0", bus.err); end
        rst = 1'b1;
        bus.fs = 1'b0;
        bus.adc_rxen = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.fd !== 1'b0) begin bad++; $display("FAIL mid_fd: got %b, expected 0", bus.fd); end
        total++; if (bus.fifod_txen !== 1'b0) begin bad++; $display("FAIL mid_txen: got %b, expected 0", bus.fifod_txen); end
        total++; if (bus.fifod_txd !== 8'h00) begin bad++; $display("FAIL mid_txd: got %h, expected 00", bus.fifod_txd); end
        total++; if (bus.data_len !== 12'h000) begin bad++; $display("FAIL mid_len: got %h, expected 000", bus.data_len); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b, expected 0", bus.err); end
        @(posedge clk); #1;
        rst = 1'b0;
        tb_seq = 8'h00;
        push_frame(8'h33, 8'h44, 0, 1'b1);
        drive_frame(8'h33, 8'h44, 0, 0, 0, 0, 0, 0, 0);
        wait_fd(50);
        total++; if (bus.fd !== 1'b1) begin bad++; $display("FAIL mid_next_fd: got %b, expected 1", bus.fd); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_next_missing: got %0d bytes unsent, expected 0", exp_q.size()); end
        end_frame();
        tb_seq++;
    endtask

    task automatic test_seq_wrap();
        for (int f = 0; f < 257; f++) begin
            push_frame(8'(f), 8'h5A, 0, 1'b1);
            drive_frame(8'(f), 8'h5A, 0, 0, 0, 0, 0, 0, 0);
            wait_fd(50);
            total++;
            if (bus.fd !== 1'b1) begin
                bad++;
                $display("FAIL wrap_fd: frame %0d got fd=%b, expected 1", f, bus.fd);
            end
            end_frame();
            tb_seq++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing: got %0d bytes unsent, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_overflow();
        test_reset_midframe();
        test_seq_wrap();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
